// File: rtl/latch_bank_wr_sched.sv
// Round-robin write scheduler for a bank of transparent D latches.
// Each write runs setup -> open -> hold so d is stable while any ena is high.
module latch_bank_wr_sched #(
    parameter int N_REQ    = 4,
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter int AW       = 3,
    parameter int OPEN_CYC = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*AW-1:0]    req_addr,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]       gnt,
    output logic [WIDTH-1:0]       d,
    output logic [DEPTH-1:0]       ena,
    output logic                   busy
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = (OPEN_CYC > 1) ? $clog2(OPEN_CYC) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        OPEN,
        HOLD
    } state_t;

    state_t            state, state_n;
    logic [PW-1:0]     ptr, ptr_n;
    logic [PW-1:0]     cap_idx, cap_idx_n;
    logic [AW-1:0]     cap_addr, cap_addr_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [WIDTH-1:0]  d_n;
    logic [DEPTH-1:0]  ena_n;
    logic [N_REQ-1:0]  gnt_n;
    logic              busy_n;

    logic              found;
    logic [PW-1:0]     win;
    int                idx;

    // Rotating-priority search starting at ptr.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = (int'(ptr) + i) % N_REQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = PW'(idx);
            end
        end
    end

    // All outputs are registered here, so ena can never glitch.
    always_comb begin
        state_n    = state;
        ptr_n      = ptr;
        cap_idx_n  = cap_idx;
        cap_addr_n = cap_addr;
        cnt_n      = cnt;
        d_n        = d;
        ena_n      = ena;
        gnt_n      = '0;
        busy_n     = busy;
        unique case (state)
            IDLE: begin
                if (found) begin
                    state_n    = SETUP;
                    cap_idx_n  = win;
                    cap_addr_n = req_addr[int'(win)*AW +: AW];
                    d_n        = req_data[int'(win)*WIDTH +: WIDTH];
                    ptr_n      = (int'(win) == N_REQ - 1) ? '0 : win + 1'b1;
                    busy_n     = 1'b1;
                end
            end
            SETUP: begin
                state_n = OPEN;
                cnt_n   = '0;
                // Out-of-range addresses match no bit, dropping the write.
                for (int j = 0; j < DEPTH; j++) begin
                    ena_n[j] = (cap_addr == AW'(j));
                end
            end
            OPEN: begin
                if (cnt == CW'(OPEN_CYC - 1)) begin
                    state_n = HOLD;
                    ena_n   = '0;
                    for (int j = 0; j < N_REQ; j++) begin
                        gnt_n[j] = (cap_idx == PW'(j));
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            HOLD: begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end
            default: begin
                state_n = IDLE;
                ena_n   = '0;
                busy_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            cap_idx  <= '0;
            cap_addr <= '0;
            cnt      <= '0;
            d        <= '0;
            ena      <= '0;
            gnt      <= '0;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            cap_idx  <= cap_idx_n;
            cap_addr <= cap_addr_n;
            cnt      <= cnt_n;
            d        <= d_n;
            ena      <= ena_n;
            gnt      <= gnt_n;
            busy     <= busy_n;
        end
    end

endmodule

// File: tb/tb_latch_bank_wr_sched.sv
// Directed bench for latch_bank_wr_sched with a behavioural latch bank.
// A second instance with DEPTH=6 covers out-of-range addresses.
module tb_latch_bank_wr_sched;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int D  = 8;
    localparam int A  = 3;
    localparam int OC = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N*A-1:0] req_addr = '0;
    logic [N*W-1:0] req_data = '0;
    logic [N-1:0]   gnt, gnt6;
    logic [W-1:0]   d, d6;
    logic [D-1:0]   ena;
    logic [5:0]     ena6;
    logic           busy, busy6;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int mon_bad = 0;
    logic [W-1:0] prev_d = '0;
    logic [W-1:0] lat [D] = '{default: '0};

    latch_bank_wr_sched #(.N_REQ(N), .WIDTH(W), .DEPTH(D), .AW(A), .OPEN_CYC(OC)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr),
        .req_data(req_data), .gnt(gnt), .d(d), .ena(ena), .busy(busy)
    );

    latch_bank_wr_sched #(.N_REQ(N), .WIDTH(W), .DEPTH(6), .AW(A), .OPEN_CYC(OC)) dut6 (
        .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr),
        .req_data(req_data), .gnt(gnt6), .d(d6), .ena(ena6), .busy(busy6)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(ena or d) begin
        for (int j = 0; j < D; j++) begin
            if (ena[j]) lat[j] = d;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if ($countones(ena) > 1) mon_bad++;
            if (ena != '0 && d !== prev_d) mon_bad++;
        end
        prev_d = d;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic setreq(input int i, input logic [A-1:0] a, input logic [W-1:0] v);
        req_addr[i*A +: A] = a;
        req_data[i*W +: W] = v;
        req[i] = 1'b1;
    endtask

    task automatic wait_gnt(output logic [N-1:0] g, output int c);
        g = '0;
        c = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (gnt != '0) begin
                g = gnt;
                c = cyc;
                break;
            end
        end
    endtask

    logic [N-1:0] g;
    int c, c_prev;

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_ena", ena, 0);
        chk("reset_d", d, 0);
        chk("reset_gnt", gnt, 0);
        chk("reset_busy", busy, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single write: req[0] addr 3 data A5
        setreq(0, 3'd3, 8'hA5);
        @(negedge clk);
        chk("t1_setup_d", d, 8'hA5);
        chk("t1_setup_ena", ena, 0);
        chk("t1_setup_busy", busy, 1);
        @(negedge clk);
        chk("t1_open0_ena", ena, 8'h08);
        @(negedge clk);
        chk("t1_open1_ena", ena, 8'h08);
        chk("t1_open1_gnt", gnt, 0);
        @(negedge clk);
        chk("t1_hold_ena", ena, 0);
        chk("t1_hold_gnt", gnt, 4'b0001);
        req = '0;
        @(negedge clk);
        chk("t1_idle_gnt", gnt, 0);
        chk("t1_idle_busy", busy, 0);
        chk("t1_idle_d", d, 8'hA5);
        chk("t1_lat3", lat[3], 8'hA5);

        // Data changes after capture are ignored
        setreq(2, 3'd7, 8'h3C);
        @(negedge clk);
        chk("t3_setup_d", d, 8'h3C);
        @(negedge clk);
        chk("t3_open0_ena", ena, 8'h80);
        req_data[2*W +: W] = 8'hFF;
        @(negedge clk);
        chk("t3_open1_d", d, 8'h3C);
        @(negedge clk);
        chk("t3_hold_gnt", gnt, 4'b0100);
        chk("t3_hold_d", d, 8'h3C);
        req = '0;
        @(negedge clk);
        chk("t3_lat7", lat[7], 8'h3C);

        // Address 6: valid for DEPTH=8, dropped for DEPTH=6
        setreq(3, 3'd6, 8'h5A);
        @(negedge clk);
        chk("t4_setup_ena6", ena6, 0);
        @(negedge clk);
        chk("t4_open0_ena6", ena6, 0);
        chk("t4_open0_ena", ena, 8'h40);
        @(negedge clk);
        chk("t4_open1_ena6", ena6, 0);
        @(negedge clk);
        chk("t4_hold_ena6", ena6, 0);
        chk("t4_hold_gnt6", gnt6, 4'b1000);
        chk("t4_hold_gnt", gnt, 4'b1000);
        req = '0;
        @(negedge clk);
        chk("t4_lat6", lat[6], 8'h5A);
        chk("t4_busy6", busy6, 0);
        chk("mon_a", mon_bad, 0);

        // All four requesting continuously from reset
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) setreq(i, A'(i), W'(8'h10 + i));
        @(negedge clk);
        rst_n = 1'b1;
        c_prev = 0;
        for (int k = 0; k < 5; k++) begin
            wait_gnt(g, c);
            chk($sformatf("t2_gnt%0d", k), g, 32'(1 << (k % N)));
            if (k > 0) chk($sformatf("t2_gap%0d", k), c - c_prev, OC + 3);
            c_prev = c;
        end
        req = '0;
        @(negedge clk);
        for (int i = 0; i < N; i++) chk($sformatf("t2_lat%0d", i), lat[i], 32'(8'h10 + i));
        chk("mon_b", mon_bad, 0);

        // Reset asserted during the first OPEN cycle
        repeat (2) @(negedge clk);
        setreq(0, 3'd5, 8'h77);
        repeat (2) @(negedge clk);
        chk("t5_open_ena", ena, 8'h20);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_ena", ena, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_d", d, 0);
        setreq(0, 3'd2, 8'h88);
        setreq(1, 3'd1, 8'h99);
        @(negedge clk);
        rst_n = 1'b1;
        wait_gnt(g, c);
        chk("t5_first", g, 4'b0001);
        req[0] = 1'b0;
        wait_gnt(g, c);
        chk("t5_second", g, 4'b0010);
        req = '0;
        @(negedge clk);
        chk("t5_lat2", lat[2], 8'h88);
        chk("t5_lat1", lat[1], 8'h99);
        chk("mon_c", mon_bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
